oven_cook_controller: RTL and testbench
=======================================

Name: oven_cook_controller

Overview:
- Consumer side of the oven's target-setting front end. It accepts the latched target temperature and cook time once both inputs are done, then runs the cook cycle: heat to target, count down the cook time while holding temperature, then signal done.
- It produces the simulated current oven temperature and remaining time for the display path, plus heater and buzzer status.
- One-second timing comes from an internal prescaler on the board clock.

Parameters:
- CLKS_PER_SEC, 50000000, clk cycles per simulated second (tick).
- AMBIENT_TEMP, 65, idle/floor temperature in degrees.
- MAX_TEMP, 500, upper clamp for the accepted target temperature.
- HEAT_RATE, 25, degrees gained per tick while heating.
- COOL_RATE, 5, degrees lost per tick while not heating.
- BUZZ_SECS, 5, ticks the buzzer stays on in DONE.

Ports:
- clk  in  1  board clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse: targets valid, begin cycle
- abort  in  1  level; cancels an active cycle
- ack  in  1  one-cycle pulse; clears DONE early
- target_temp  in  10  requested temperature, degrees
- target_time  in  13  requested cook time, seconds
- current_temp  out  10  simulated oven temperature
- remaining_time  out  13  seconds left in COOK
- heater_on  out  1  heater command
- state  out  2  IDLE=0, PREHEAT=1, COOK=2, DONE=3
- done  out  1  high while in DONE
- buzzer  out  1  high during DONE buzz window

Behaviour:
- Reset: sampled on posedge clk when rst_n=0; rst_n has priority over everything. Values on reset: state=IDLE, current_temp=AMBIENT_TEMP, remaining_time=0, heater_on=0, done=0, buzzer=0, prescaler=0, buzz counter=0. A reset mid-cycle aborts the cycle with no residual state.
- Prescaler: counts 0..CLKS_PER_SEC-1 and wraps. tick=1 for the single cycle where the count equals CLKS_PER_SEC-1. The prescaler is forced to 0 in the cycle a start is accepted, so the first tick comes CLKS_PER_SEC cycles after the accept.
- All outputs are registered. heater_on, done and buzzer reflect the registered state and temperature.
- Start acceptance:
  - A start is accepted only when state=IDLE and target_time!=0. Otherwise it is ignored.
  - On accept: tgt_temp latches clamp(target_temp, AMBIENT_TEMP, MAX_TEMP), tgt_time latches min(target_time, 8191), and state becomes PREHEAT.
  - Inputs are not re-sampled during the cycle.
- IDLE: heater_on=0. On each tick, current_temp = max(current_temp-COOL_RATE, AMBIENT_TEMP).
- PREHEAT:
  - heater_on=1. On each tick, current_temp = min(current_temp+HEAT_RATE, tgt_temp).
  - When current_temp>=tgt_temp (registered value), the next clk enters COOK and remaining_time=tgt_time. This check does not wait for a tick.
  - If the oven is already at or above tgt_temp, COOK is entered one cycle after PREHEAT.
- COOK:
  - heater_on = (current_temp < tgt_temp).
  - On tick, temperature moves toward tgt_temp without overshoot:
    - if below, +min(HEAT_RATE, diff);
    - if above, -min(COOL_RATE, diff);
    - if equal, unchanged.
  - On the same tick, remaining_time decrements by 1.
  - The tick that takes remaining_time from 1 to 0 also moves state to DONE.
- DONE:
  - done=1, heater_on=0, and current_temp cools as in IDLE.
  - buzzer=1 from DONE entry for BUZZ_SECS ticks. A buzz counter increments on each tick.
  - The tick that reaches BUZZ_SECS moves state to IDLE; buzzer and done drop on that transition.
  - ack in DONE moves state to IDLE on the next clk regardless of the buzz counter.
- Abort:
  - abort=1 in PREHEAT or COOK moves state to IDLE on the next clk and sets remaining_time=0 and heater_on=0.
  - Abort wins over a same-cycle tick: no temperature or time update happens in that cycle.
  - abort is ignored in IDLE and DONE.
- Simultaneous inputs: start and abort together in IDLE means start wins; abort then acts in the following cycles while it is still held.
- Width rules: all temperature arithmetic is done in 11 bits, so no wrap occurs. current_temp always stays within [AMBIENT_TEMP, MAX_TEMP].

Test Plan:
(Bench uses CLKS_PER_SEC=4, HEAT_RATE=25, COOL_RATE=5, AMBIENT_TEMP=65, BUZZ_SECS=2.)
- Reset: hold rst_n=0 for 3 clk then release -> current_temp=65, remaining_time=0, state=0, heater_on=0, done=0, buzzer=0.
- Normal cycle: start, target_temp=165, target_time=3.
  - PREHEAT temp sequence 90, 115, 140, 165 on ticks at clk 4, 8, 12, 16 after accept.
  - COOK with remaining_time=3, then 2, 1, 0 on successive ticks; DONE on the tick that reaches 0.
  - buzzer=1 for 2 ticks, then IDLE, then temp cools 160, 155, ...
- Clamp: target_temp=600 -> PREHEAT stops at 500. target_temp=30 -> PREHEAT ends immediately; COOK holds 65.
- Abort mid-COOK at remaining_time=2 with temp=165 -> IDLE next clk, remaining_time=0, heater_on=0. On later ticks temp goes 160, 155.
- Ignored starts:
  - target_time=0 in IDLE -> state stays 0.
  - start pulse during COOK -> no change to remaining_time or latched targets.
- Reset mid-PREHEAT at temp=115 -> all reset values next clk. A following start behaves as in the normal-cycle scenario from 65.

Source files
------------

// File: rtl/oven_cook_controller.sv
// -----------------------------------------------------------------------------
// oven_cook_controller
//
// Runs one oven cook cycle. A start pulse latches the target temperature
// (clamped to [AMBIENT_TEMP, MAX_TEMP]) and the cook time. The oven then
// preheats to the target, holds it while the cook time counts down, and
// finally sits in DONE with the buzzer on for BUZZ_SECS seconds. Oven
// temperature is simulated: it rises by HEAT_RATE per second while heating
// and falls by COOL_RATE per second otherwise. One-second ticks come from a
// free-running prescaler on clk that restarts whenever a cycle is accepted.
//
// Ports
//   clk            board clock
//   rst_n          synchronous active-low reset
//   start          one-cycle pulse, accepted in IDLE when target_time != 0
//   abort          level, cancels PREHEAT/COOK
//   ack            one-cycle pulse, leaves DONE early
//   target_temp    requested temperature (degrees)
//   target_time    requested cook time (seconds)
//   current_temp   simulated oven temperature (degrees)
//   remaining_time seconds left in COOK
//   heater_on      heater command
//   state          IDLE=0, PREHEAT=1, COOK=2, DONE=3
//   done           high while in DONE
//   buzzer         high during the DONE buzz window
// -----------------------------------------------------------------------------
module oven_cook_controller #(
  parameter int CLKS_PER_SEC = 50000000,
  parameter int AMBIENT_TEMP = 65,
  parameter int MAX_TEMP     = 500,
  parameter int HEAT_RATE    = 25,
  parameter int COOL_RATE    = 5,
  parameter int BUZZ_SECS    = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        ack,
  input  logic [9:0]  target_temp,
  input  logic [12:0] target_time,
  output logic [9:0]  current_temp,
  output logic [12:0] remaining_time,
  output logic        heater_on,
  output logic [1:0]  state,
  output logic        done,
  output logic        buzzer
);

  localparam int PW = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
  localparam int BW = (BUZZ_SECS > 0) ? $clog2(BUZZ_SECS + 1) : 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(CLKS_PER_SEC - 1);
  localparam logic [BW-1:0] BUZZ_LIM  = BW'(BUZZ_SECS);
  localparam logic [BW-1:0] BUZZ_LAST = BW'((BUZZ_SECS > 0) ? BUZZ_SECS - 1 : 0);

  localparam logic [10:0] AMB_T  = 11'(AMBIENT_TEMP);
  localparam logic [10:0] MAX_T  = 11'(MAX_TEMP);
  localparam logic [10:0] HEAT_T = 11'(HEAT_RATE);
  localparam logic [10:0] COOL_T = 11'(COOL_RATE);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PREHEAT = 2'd1,
    S_COOK    = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // All temperature arithmetic is 11 bits wide so sums and differences of
  // in-range 10-bit temperatures can never wrap.
  function automatic logic [10:0] clamp_target(input logic [9:0] t);
    logic [10:0] x;
    x = {1'b0, t};
    if (x < AMB_T)      return AMB_T;
    else if (x > MAX_T) return MAX_T;
    else                return x;
  endfunction

  // Rise toward ceil without passing it.
  function automatic logic [10:0] heat_toward(input logic [10:0] cur,
                                              input logic [10:0] ceil);
    logic [10:0] sum;
    sum = cur + HEAT_T;
    return (sum > ceil) ? ceil : sum;
  endfunction

  // Fall toward floor without passing it.
  function automatic logic [10:0] cool_toward(input logic [10:0] cur,
                                              input logic [10:0] floor);
    return (cur >= floor + COOL_T) ? (cur - COOL_T) : floor;
  endfunction

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] buzz_cnt_q, buzz_cnt_d;
  logic [9:0]    temp_q, temp_d;
  logic [9:0]    tgt_temp_q, tgt_temp_d;
  logic [12:0]   tgt_time_q, tgt_time_d;
  logic [12:0]   rem_q, rem_d;
  logic          heater_q, heater_d;
  logic          done_q, done_d;
  logic          buzzer_q, buzzer_d;

  logic        tick;
  logic        accept;
  logic        at_target;
  logic [10:0] temp_nx;
  logic [10:0] tgt_clamped;

  assign tick      = (presc_q == PRESC_MAX);
  assign accept    = (state_q == S_IDLE) && start && (target_time != 13'd0);
  assign at_target = (temp_q >= tgt_temp_q);

  // ---- state and datapath registers ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      presc_q    <= '0;
      buzz_cnt_q <= '0;
      temp_q     <= AMB_T[9:0];
      tgt_temp_q <= AMB_T[9:0];
      tgt_time_q <= '0;
      rem_q      <= '0;
      heater_q   <= 1'b0;
      done_q     <= 1'b0;
      buzzer_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      buzz_cnt_q <= buzz_cnt_d;
      temp_q     <= temp_d;
      tgt_temp_q <= tgt_temp_d;
      tgt_time_q <= tgt_time_d;
      rem_q      <= rem_d;
      heater_q   <= heater_d;
      done_q     <= done_d;
      buzzer_q   <= buzzer_d;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_PREHEAT;
      end
      S_PREHEAT: begin
        if (abort)          state_d = S_IDLE;
        else if (at_target) state_d = S_COOK;
      end
      S_COOK: begin
        if (abort)                         state_d = S_IDLE;
        else if (tick && rem_q <= 13'd1)   state_d = S_DONE;
      end
      S_DONE: begin
        if (ack)                                 state_d = S_IDLE;
        else if (tick && buzz_cnt_q >= BUZZ_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---- datapath and registered-output logic ----
  always_comb begin
    presc_d     = (accept || tick) ? '0 : presc_q + 1'b1;
    tgt_temp_d  = tgt_temp_q;
    tgt_time_d  = tgt_time_q;
    rem_d       = rem_q;
    buzz_cnt_d  = '0;
    temp_nx     = {1'b0, temp_q};
    tgt_clamped = clamp_target(target_temp);

    case (state_q)
      S_IDLE: begin
        if (tick) temp_nx = cool_toward({1'b0, temp_q}, AMB_T);
        if (accept) begin
          tgt_temp_d = tgt_clamped[9:0];
          tgt_time_d = target_time;
        end
      end
      S_PREHEAT: begin
        // Abort freezes temperature even on a tick.
        if (abort) begin
          rem_d = '0;
        end else if (at_target) begin
          rem_d = tgt_time_q;
        end else if (tick) begin
          temp_nx = heat_toward({1'b0, temp_q}, {1'b0, tgt_temp_q});
        end
      end
      S_COOK: begin
        if (abort) begin
          rem_d = '0;
        end else if (tick) begin
          rem_d = rem_q - 1'b1;
          if (temp_q < tgt_temp_q)
            temp_nx = heat_toward({1'b0, temp_q}, {1'b0, tgt_temp_q});
          else if (temp_q > tgt_temp_q)
            temp_nx = cool_toward({1'b0, temp_q}, {1'b0, tgt_temp_q});
        end
      end
      S_DONE: begin
        if (tick) begin
          temp_nx    = cool_toward({1'b0, temp_q}, AMB_T);
          buzz_cnt_d = buzz_cnt_q + 1'b1;
        end else begin
          buzz_cnt_d = buzz_cnt_q;
        end
      end
      default: ;
    endcase

    temp_d = temp_nx[9:0];

    // Status flags are derived from the next state/temperature so that the
    // registered outputs always agree with the registered state.
    heater_d = (state_d == S_PREHEAT) ||
               ((state_d == S_COOK) && (temp_d < tgt_temp_d));
    done_d   = (state_d == S_DONE);
    buzzer_d = (state_d == S_DONE) && (buzz_cnt_d < BUZZ_LIM);
  end

  assign current_temp   = temp_q;
  assign remaining_time = rem_q;
  assign heater_on      = heater_q;
  assign state          = state_q;
  assign done           = done_q;
  assign buzzer         = buzzer_q;

endmodule

// File: tb/tb_oven_cook_controller.sv
// -----------------------------------------------------------------------------
// tb_oven_cook_controller
//
// Directed scenarios with hand-computed expected snapshots. Each snapshot is
// queued with the clock-edge index it belongs to; a monitor on the falling
// edge pops and compares every snapshot whose edge has been reached.
// -----------------------------------------------------------------------------
module tb_oven_cook_controller;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        ack;
  logic [9:0]  target_temp;
  logic [12:0] target_time;
  logic [9:0]  current_temp;
  logic [12:0] remaining_time;
  logic        heater_on;
  logic [1:0]  state;
  logic        done;
  logic        buzzer;

  oven_cook_controller #(
    .CLKS_PER_SEC(4),
    .AMBIENT_TEMP(65),
    .MAX_TEMP    (500),
    .HEAT_RATE   (25),
    .COOL_RATE   (5),
    .BUZZ_SECS   (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .ack           (ack),
    .target_temp   (target_temp),
    .target_time   (target_time),
    .current_temp  (current_temp),
    .remaining_time(remaining_time),
    .heater_on     (heater_on),
    .state         (state),
    .done          (done),
    .buzzer        (buzzer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: after the k-th rising edge cyc == k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] c;
    logic [9:0]  t;
    logic [12:0] r;
    logic [1:0]  st;
    logic        h;
    logic        d;
    logic        b;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  task automatic expect_at(input int c, input string nm, input int t, input int r,
                           input int st, input bit h, input bit d, input bit b);
    exp_t e;
    e.c  = 32'(c);
    e.t  = 10'(t);
    e.r  = 13'(r);
    e.st = 2'(st);
    e.h  = h;
    e.d  = d;
    e.b  = b;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: compares every queued snapshot due at the current edge.
  always @(negedge clk) begin
    exp_t  e;
    string nm;
    while (exp_q.size() > 0 && int'(exp_q[0].c) <= cyc) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_checks++;
      if (int'(e.c) < cyc) begin
        $display("FAIL %s: snapshot for edge %0d missed (now %0d)", nm, e.c, cyc);
      end else if (current_temp === e.t && remaining_time === e.r && state === e.st &&
                   heater_on === e.h && done === e.d && buzzer === e.b) begin
        n_pass++;
      end else begin
        $display("FAIL %s @edge %0d: got temp=%0d rem=%0d st=%0d ht=%0b dn=%0b bz=%0b, expected temp=%0d rem=%0d st=%0d ht=%0b dn=%0b bz=%0b",
                 nm, cyc, current_temp, remaining_time, state, heater_on, done, buzzer,
                 e.t, e.r, e.st, e.h, e.d, e.b);
      end
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One reset edge; returns just after it with rst_n released.
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Drives a one-cycle start; a is the edge at which it is sampled.
  task automatic issue_start(input int tt, input int tm, output int a);
    target_temp = 10'(tt);
    target_time = 13'(tm);
    start       = 1'b1;
    a           = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Snapshots shared by every normal 165-degree / 3-second run.
  task automatic expect_normal_head(input int a, input string tag);
    expect_at(a,      {tag, "_accept"}, 65,  0, 1, 1, 0, 0);
    expect_at(a + 4,  {tag, "_heat1"},  90,  0, 1, 1, 0, 0);
    expect_at(a + 8,  {tag, "_heat2"},  115, 0, 1, 1, 0, 0);
  endtask

  int a;

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    ack         = 1'b0;
    target_temp = '0;
    target_time = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    expect_at(cyc, "reset", 65, 0, 0, 0, 0, 0);

    // Normal cycle: 165 degrees, 3 seconds
    issue_start(165, 3, a);
    expect_normal_head(a, "norm");
    expect_at(a + 12, "norm_heat3",   140, 0, 1, 1, 0, 0);
    expect_at(a + 16, "norm_heat4",   165, 0, 1, 1, 0, 0);
    expect_at(a + 17, "norm_cook",    165, 3, 2, 0, 0, 0);
    expect_at(a + 20, "norm_rem2",    165, 2, 2, 0, 0, 0);
    expect_at(a + 24, "norm_rem1",    165, 1, 2, 0, 0, 0);
    expect_at(a + 27, "norm_rem1b",   165, 1, 2, 0, 0, 0);
    expect_at(a + 28, "norm_done",    165, 0, 3, 0, 1, 1);
    expect_at(a + 32, "norm_buzz2",   160, 0, 3, 0, 1, 1);
    expect_at(a + 36, "norm_idle",    155, 0, 0, 0, 0, 0);
    expect_at(a + 40, "norm_cool",    150, 0, 0, 0, 0, 0);
    wait_cyc(a + 41);

    // Clamp high: 600 -> 500, 1 second, ack leaves DONE early
    do_reset();
    issue_start(600, 1, a);
    expect_at(a,      "hi_accept", 65,  0, 1, 1, 0, 0);
    expect_at(a + 68, "hi_490",    490, 0, 1, 1, 0, 0);
    expect_at(a + 72, "hi_500",    500, 0, 1, 1, 0, 0);
    expect_at(a + 73, "hi_cook",   500, 1, 2, 0, 0, 0);
    expect_at(a + 76, "hi_done",   500, 0, 3, 0, 1, 1);
    expect_at(a + 77, "hi_ack",    500, 0, 0, 0, 0, 0);
    wait_cyc(a + 76);
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    wait_cyc(a + 78);

    // Clamp low: 30 -> 65, 2 seconds; ignored start in COOK; abort ignored in DONE
    do_reset();
    issue_start(30, 2, a);
    expect_at(a,     "lo_accept",   65, 0, 1, 1, 0, 0);
    expect_at(a + 1, "lo_cook",     65, 2, 2, 0, 0, 0);
    expect_at(a + 4, "lo_rem1",     65, 1, 2, 0, 0, 0);
    expect_at(a + 6, "lo_ign_start", 65, 1, 2, 0, 0, 0);
    expect_at(a + 8, "lo_done",     65, 0, 3, 0, 1, 1);
    expect_at(a + 9, "lo_ign_abort", 65, 0, 3, 0, 1, 1);
    wait_cyc(a + 4);
    begin
      int dummy;
      issue_start(300, 7, dummy);
    end
    wait_cyc(a + 8);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_cyc(a + 10);

    // Abort mid-COOK, then zero-time start ignored in IDLE
    do_reset();
    issue_start(165, 3, a);
    expect_normal_head(a, "ab");
    expect_at(a + 17, "ab_cook",      165, 3, 2, 0, 0, 0);
    expect_at(a + 20, "ab_rem2",      165, 2, 2, 0, 0, 0);
    expect_at(a + 21, "ab_abort",     165, 0, 0, 0, 0, 0);
    expect_at(a + 24, "ab_cool1",     160, 0, 0, 0, 0, 0);
    expect_at(a + 28, "ab_cool2",     155, 0, 0, 0, 0, 0);
    expect_at(a + 30, "zero_time",    155, 0, 0, 0, 0, 0);
    wait_cyc(a + 20);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_cyc(a + 29);
    begin
      int dummy;
      issue_start(200, 0, dummy);
    end
    wait_cyc(a + 31);

    // Start and abort together in IDLE: start wins, held abort acts next
    do_reset();
    abort = 1'b1;
    issue_start(165, 3, a);
    expect_at(a,     "sa_start", 65, 0, 1, 1, 0, 0);
    expect_at(a + 1, "sa_abort", 65, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    abort = 1'b0;
    wait_cyc(a + 2);

    // Reset mid-PREHEAT, then a fresh normal start
    do_reset();
    issue_start(165, 3, a);
    expect_normal_head(a, "rp");
    expect_at(a + 9, "rp_reset", 65, 0, 0, 0, 0, 0);
    wait_cyc(a + 8);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue_start(165, 3, a);
    expect_at(a + 4,  "rp2_heat1", 90,  0, 1, 1, 0, 0);
    expect_at(a + 17, "rp2_cook",  165, 3, 2, 0, 0, 0);
    wait_cyc(a + 19);

    // Every queued snapshot must have been consumed
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d snapshots left, required 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at edge %0d, required finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
